sprite_store: RTL and testbench
===============================

# sprite_store

Double-buffered sprite bitmap memory that serves the pixel-fetch side of the sprite renderer: the renderer drives a pixel index `pos` and receives the stored colour one cycle later. A load port accepts a new bitmap as a valid/ready pixel stream into the hidden (back) bank. The banks swap only at a frame boundary, so a sprite is never torn mid-frame. The block sits between the bitmap source (SRAM/UART loader) and the sprite renderer.

## Interface
- `WIDTH`, 8, sprite width in pixels
- `HEIGHT`, 8, sprite height in pixels
- `COLR_BITS`, 4, bits per pixel colour index
- `ADDRW`, 6, pixel index width; must equal clog2(WIDTH*HEIGHT)

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `pos`  in  ADDRW  renderer pixel index, row-major (y*WIDTH + x)
- `data_out`  out  COLR_BITS  colour at `pos` from the front bank, registered
- `load_start`  in  1  begin loading a new bitmap into the back bank
- `load_abort`  in  1  abandon the current load; no swap occurs
- `load_valid`  in  1  `load_data` is valid this cycle
- `load_data`  in  COLR_BITS  next pixel, row-major order
- `load_ready`  out  1  block accepts a pixel this cycle
- `frame_end`  in  1  single-cycle pulse at the end of the visible frame
- `load_done`  out  1  one-cycle pulse when the swap occurs
- `busy`  out  1  high when the state is not IDLE
- `bank`  out  1  index of the current front bank

## Operation
- Storage: 2*WIDTH*HEIGHT words of COLR_BITS, implemented as inferred RAM.
  - Read address is {`bank`, `pos`}.
  - Write address is {~`bank`, `waddr`}.
  - `waddr` is ADDRW bits wide.
- Read path: every cycle, `data_out` <= mem[{`bank`, `pos`}].
  - If `pos` >= WIDTH*HEIGHT, `data_out` <= 0.
- FSM has three states: IDLE, LOAD, WAIT_SWAP.
- IDLE:
  - `load_start` -> LOAD, with `waddr` <= 0.
  - `frame_end` is ignored.
- LOAD:
  - `load_ready` = 1.
  - On `load_valid` & `load_ready`, the block writes `load_data` to the back bank at `waddr`, then `waddr` <= `waddr` + 1.
  - A write at `waddr` == WIDTH*HEIGHT-1 -> WAIT_SWAP.
  - `load_abort` -> IDLE. Abort takes priority over a same-cycle write; that pixel is not written. The back bank is left partially written and `bank` is unchanged.
  - `frame_end` is ignored.
- WAIT_SWAP:
  - `load_ready` = 0.
  - `frame_end` -> IDLE, with `bank` <= ~`bank` and `load_done` = 1 for that cycle (registered, visible the following cycle).
  - `load_abort` -> IDLE with no swap. Abort wins over a simultaneous `frame_end`.
- `load_start` outside IDLE is ignored.
- Arithmetic: `waddr` increment is ADDRW-bit and never wraps in use, because the transition to WAIT_SWAP happens on the last address.
- Memory contents are not reset; they are undefined until loaded.

## Timing
- Reset values:
  - state = IDLE, `bank` = 0, `waddr` = 0.
  - `data_out` = 0, `load_ready` = 0, `load_done` = 0, `busy` = 0.
- Reset asserted mid-load returns the block to IDLE immediately. The partial back-bank data is abandoned.
- Read latency is 1 cycle: `pos` sampled at edge N appears on `data_out` after edge N. The renderer issues `pos` one cycle ahead of display.
- `load_ready` and `busy` are combinational from state. `load_ready` rises the cycle after `load_start` is sampled.
- Maximum load throughput is 1 pixel/cycle; WIDTH*HEIGHT pixels take WIDTH*HEIGHT accepted cycles.
- Swap timing:
  - `bank` changes on the edge that samples `frame_end` in WAIT_SWAP.
  - Reads issued after that edge use the new bank.
  - `load_done` is high for exactly the cycle after that edge.
- A final write and `frame_end` in the same LOAD cycle: the write is taken and the state becomes WAIT_SWAP, but the swap waits for the next `frame_end`.
- A read of the front bank during a back-bank write never observes the new data.

## Test plan
- Reset: assert `rst_n`=0 mid-LOAD -> `bank`=0, `load_ready`=0, `busy`=0, `data_out`=0 the cycle after release.
- Full load and swap (8x8): `load_start`, stream pixels value = index%16 with `load_valid` held high -> `load_ready` drops after 64 accepts. Then `frame_end` -> `bank`=1 and `load_done` pulses 1 cycle. Sweep `pos`=0..63 -> `data_out` = `pos`%16, each 1 cycle after its `pos`.
- No tearing: while the second load streams 0xF into bank 0, read `pos`=5 repeatedly -> `data_out` stays 5 until `frame_end`, then reads 0xF.
- Backpressure gaps: toggle `load_valid` every other cycle -> exactly 64 writes land, with no duplicate or skipped addresses.
- Abort: `load_abort` after 20 pixels -> IDLE, `bank` unchanged. A later `frame_end` causes no swap and no `load_done`.
- Boundaries:
  - `frame_end` on the same cycle as the 64th write -> no swap; swap occurs on the next `frame_end`.
  - `pos`=64 with ADDRW=7 instance -> `data_out`=0.

Source files
------------

// File: rtl/sprite_store_if.sv
// Load-side handshake between the bitmap source and the sprite store.
// The source streams pixels on valid/ready; the store pulses load_done on swap.
interface sprite_store_if #(
  parameter int COLR_BITS = 4
);
  logic                 load_start;
  logic                 load_abort;
  logic                 load_valid;
  logic [COLR_BITS-1:0] load_data;
  logic                 load_ready;
  logic                 load_done;

  modport master (
    output load_start, load_abort, load_valid, load_data,
    input  load_ready, load_done
  );

  modport slave (
    input  load_start, load_abort, load_valid, load_data,
    output load_ready, load_done
  );
endinterface

// File: rtl/sprite_store.sv
// Double-buffered sprite bitmap: renderer reads the front bank with one cycle
// latency while a new bitmap streams into the back bank; banks swap at frame end.
module sprite_store #(
  parameter int WIDTH     = 8,
  parameter int HEIGHT    = 8,
  parameter int COLR_BITS = 4,
  parameter int ADDRW     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDRW-1:0]     pos,
  output logic [COLR_BITS-1:0] data_out,
  sprite_store_if.slave        ld,
  input  logic                 frame_end,
  output logic                 busy,
  output logic                 bank
);
  localparam int             NPIX = WIDTH * HEIGHT;
  localparam int             AW   = $clog2(NPIX);
  localparam logic [ADDRW:0] NPIX_W = (ADDRW+1)'(NPIX);
  localparam logic [ADDRW-1:0] LAST = ADDRW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t               state_q, state_d;
  logic [ADDRW-1:0]     waddr;
  logic                 wr_en, swap, start;
  logic                 done_q;
  logic [COLR_BITS-1:0] mem [2*NPIX];
  logic [AW:0]          rd_idx, wr_idx;
  logic                 pos_oob;

  assign ld.load_ready = (state_q == LOAD);
  assign ld.load_done  = done_q;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Abort outranks both a same-cycle write and a same-cycle frame_end.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    swap    = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld.load_start) begin
          state_d = LOAD;
          start   = 1'b1;
        end
      end
      LOAD: begin
        if (ld.load_abort) begin
          state_d = IDLE;
        end else if (ld.load_valid) begin
          wr_en = 1'b1;
          if (waddr == LAST) state_d = WAIT_SWAP;
        end
      end
      WAIT_SWAP: begin
        if (ld.load_abort) begin
          state_d = IDLE;
        end else if (frame_end) begin
          state_d = IDLE;
          swap    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank   <= 1'b0;
      waddr  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= swap;
      if (swap)  bank <= ~bank;
      if (start) waddr <= '0;
      else if (wr_en) waddr <= waddr + 1'b1;
    end
  end

  assign wr_idx  = {~bank, waddr[AW-1:0]};
  assign rd_idx  = {bank, pos[AW-1:0]};
  assign pos_oob = ({1'b0, pos} >= NPIX_W);

  // Back-bank writes never alias the front bank, so reads see only old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= ld.load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       data_out <= '0;
    else if (pos_oob) data_out <= '0;
    else              data_out <= mem[rd_idx];
  end
endmodule

// File: tb/tb_sprite_store.sv
// Directed bench for sprite_store: load/swap, tearing, backpressure, abort,
// same-cycle final write with frame_end, and out-of-range read on a wide index.
module tb_sprite_store;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] pos;
  logic [6:0] pos_big;
  logic [3:0] data_out, data_out_big;
  logic       frame_end, busy, bank, busy_big, bank_big;
  logic       load_start, load_abort, load_valid;
  logic [3:0] load_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sprite_store_if #(.COLR_BITS(4)) ld_a ();
  sprite_store_if #(.COLR_BITS(4)) ld_b ();

  assign ld_a.load_start = load_start;
  assign ld_a.load_abort = load_abort;
  assign ld_a.load_valid = load_valid;
  assign ld_a.load_data  = load_data;
  assign ld_b.load_start = load_start;
  assign ld_b.load_abort = load_abort;
  assign ld_b.load_valid = load_valid;
  assign ld_b.load_data  = load_data;

  sprite_store #(.WIDTH(8), .HEIGHT(8), .COLR_BITS(4), .ADDRW(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .pos(pos), .data_out(data_out), .ld(ld_a),
    .frame_end(frame_end), .busy(busy), .bank(bank)
  );

  sprite_store #(.WIDTH(8), .HEIGHT(8), .COLR_BITS(4), .ADDRW(7)) u_big (
    .clk(clk), .rst_n(rst_n), .pos(pos_big), .data_out(data_out_big), .ld(ld_b),
    .frame_end(frame_end), .busy(busy_big), .bank(bank_big)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, cyc;
    rst_n = 1'b0; pos = '0; pos_big = '0; frame_end = 1'b0;
    load_start = 1'b0; load_abort = 1'b0; load_valid = 1'b0; load_data = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // reset asserted in the middle of a load
    start_load();
    for (int i = 0; i < 3; i++) push(4'(i));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_bank", bank, 0);
    check("rst_ready", ld_a.load_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", data_out, 0);
    check("rst_done", ld_a.load_done, 0);
    tick();
    check("rst_busy_after", busy, 0);

    // full load and swap
    start_load();
    check("load_ready_up", ld_a.load_ready, 1);
    check("load_busy", busy, 1);
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("ready_before_last", ld_a.load_ready, 1);
      push(4'(i % 16));
    end
    check("ready_drop", ld_a.load_ready, 0);
    check("wait_busy", busy, 1);
    check("wait_bank", bank, 0);
    pulse_frame_end();
    check("swap_bank", bank, 1);
    check("swap_done", ld_a.load_done, 1);
    tick();
    check("done_one_cycle", ld_a.load_done, 0);
    check("idle_busy", busy, 0);
    for (int p = 0; p < 64; p++) begin
      pos = 6'(p);
      tick();
      check("sweep1", data_out, p % 16);
    end

    // front bank stays stable while the back bank fills
    pos = 6'd5;
    tick();
    start_load();
    for (int i = 0; i < 64; i++) begin
      push(4'hF);
      if (i % 16 == 0) check("no_tear", data_out, 5);
    end
    tick();
    check("no_tear_wait", data_out, 5);
    pulse_frame_end();
    check("tear_swap_bank", bank, 0);
    check("tear_swap_edge", data_out, 5);
    tick();
    check("tear_new", data_out, 4'hF);

    // valid toggling every other cycle
    start_load();
    acc = 0; cyc = 0;
    while (acc < 64 && cyc < 300) begin
      load_valid = (cyc % 2 == 0);
      load_data  = 4'(15 - acc % 16);
      if (load_valid && ld_a.load_ready) acc++;
      tick();
      cyc++;
    end
    load_valid = 1'b0;
    check("bp_accepts", acc, 64);
    check("bp_cycles", cyc, 127);
    check("bp_ready_drop", ld_a.load_ready, 0);
    pulse_frame_end();
    check("bp_bank", bank, 1);
    for (int p = 0; p < 64; p++) begin
      pos = 6'(p);
      tick();
      check("sweep_bp", data_out, 15 - p % 16);
    end

    // abort after 20 pixels
    start_load();
    for (int i = 0; i < 20; i++) push(4'hA);
    load_valid = 1'b1; load_data = 4'hA; load_abort = 1'b1;
    tick();
    load_valid = 1'b0; load_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", ld_a.load_ready, 0);
    check("abort_bank", bank, 1);
    pulse_frame_end();
    check("abort_no_swap", bank, 1);
    check("abort_no_done", ld_a.load_done, 0);
    pos = 6'd3;
    tick();
    check("abort_front", data_out, 12);

    // frame_end together with the final write does not swap
    start_load();
    for (int i = 0; i < 64; i++) begin
      frame_end = (i == 63);
      push(4'((i + 7) % 16));
    end
    frame_end = 1'b0;
    check("late_busy", busy, 1);
    check("late_ready", ld_a.load_ready, 0);
    check("late_bank", bank, 1);
    check("late_done", ld_a.load_done, 0);
    tick();
    check("late_still", bank, 1);
    pulse_frame_end();
    check("late_swap", bank, 0);
    check("late_swap_done", ld_a.load_done, 1);
    pos = 6'd0;
    tick();
    check("late_pos0", data_out, 7);
    pos = 6'd63;
    tick();
    check("late_pos63", data_out, 6);

    // wide-index instance: out-of-range pixel reads as zero
    check("big_bank", bank_big, 0);
    pos_big = 7'd64;
    tick();
    check("big_pos64", data_out_big, 0);
    pos_big = 7'd1;
    tick();
    check("big_pos1", data_out_big, 8);
    pos_big = 7'd127;
    tick();
    check("big_pos127", data_out_big, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
